// File: rtl/led_bar_pkg.sv
// Shared definitions for the LED bar animator: FSM state encoding and the
// MSB-first bar fill helper.
package led_bar_pkg;

  // Widest bar the fill helper can describe.
  localparam int BAR_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_t;

  // Top 'count' bits of a 'width'-bit bar set, the rest clear.
  function automatic logic [BAR_MAX-1:0] bar_pattern(input int count, input int width);
    logic [BAR_MAX-1:0] pat;
    pat = '0;
    for (int i = 0; i < BAR_MAX; i++) begin
      if ((i < width) && (i >= width - count)) begin
        pat[i] = 1'b1;
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/led_bar_tick.sv
// Enabled divider: emits a one-cycle tick every DIV enabled cycles.
// A synchronous clear returns the count to zero.
module led_bar_tick
  import led_bar_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrapping to zero on the tick.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_bar_animator.sv
// N-LED bar graph driver. The displayed count walks one LED per animation
// step toward the saturated level input; the bar fills MSB-first.
// Optional feature macro: LED_BAR_BLINK_FULL_EN -- blink a full, idle bar
// with a BLINK_DIV-cycle half-period. Without it a full bar is steady.
module led_bar_animator
  import led_bar_pkg::*;
#(
  parameter int LED_COUNT = 4,
  parameter int LEVEL_W   = 3,
  parameter int STEP_DIV  = 10_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [LEVEL_W-1:0]   i_level,
  output logic [LED_COUNT-1:0] o_led,
  output logic [LEVEL_W-1:0]   o_count,
  output logic                 o_busy
);

  localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(LED_COUNT);

  if ((LED_COUNT < 1) || (LED_COUNT > BAR_MAX) || (LED_COUNT >= (1 << LEVEL_W)) ||
      (STEP_DIV < 1) || (BLINK_DIV < 1)) begin : g_param_check
    $error("led_bar_animator: illegal parameter combination");
  end

  state_t               state;
  state_t               state_next;
  logic [LEVEL_W-1:0]   r_target;
  logic [LEVEL_W-1:0]   r_count;
  logic [LEVEL_W-1:0]   count_next;
  logic [LED_COUNT-1:0] led;
  logic [LED_COUNT-1:0] led_next;
  logic                 busy;
  logic                 step_en;
  logic                 step_clear;
  logic                 step_tick;

  // Capture the requested level every cycle, saturated to the bar length.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_target <= '0;
    end else begin
      r_target <= (i_level > FULL) ? FULL : i_level;
    end
  end

  // Step prescaler runs only while animating and sits at zero in IDLE.
  assign step_en    = (state != ST_IDLE);
  assign step_clear = i_reset || !step_en;

  led_bar_tick #(
    .DIV (STEP_DIV)
  ) u_step_tick (
    .clk   (i_clk),
    .clear (step_clear),
    .en    (step_en),
    .tick  (step_tick)
  );

  // Next state and count. The step direction is decided at the tick from the
  // current target, so a mid-ramp reversal takes effect on the very next step.
  always_comb begin
    state_next = state;
    count_next = r_count;
    case (state)
      ST_IDLE: begin
        if (r_target > r_count) begin
          state_next = ST_RISE;
        end else if (r_target < r_count) begin
          state_next = ST_FALL;
        end
      end
      ST_RISE, ST_FALL: begin
        if (step_tick) begin
          if (r_target > r_count) begin
            count_next = r_count + LEVEL_W'(1);
          end else if (r_target < r_count) begin
            count_next = r_count - LEVEL_W'(1);
          end
          if (r_target > count_next) begin
            state_next = ST_RISE;
          end else if (r_target < count_next) begin
            state_next = ST_FALL;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef LED_BAR_BLINK_FULL_EN
  logic full_idle;
  logic full_idle_next;
  logic blink_tick;
  logic blink_clear;
  logic phase;
  logic phase_next;

  assign full_idle   = (state == ST_IDLE) && (r_count == FULL);
  assign blink_clear = i_reset || !full_idle;

  led_bar_tick #(
    .DIV (BLINK_DIV)
  ) u_blink_tick (
    .clk   (i_clk),
    .clear (blink_clear),
    .en    (full_idle),
    .tick  (blink_tick)
  );

  // Phase is forced on outside full-idle, so every entry starts lit and
  // leaving full shows the steady pattern on the same cycle.
  always_comb begin
    full_idle_next = (state_next == ST_IDLE) && (count_next == FULL);
    phase_next     = phase;
    if (!full_idle_next) begin
      phase_next = 1'b1;
    end else if (blink_tick) begin
      phase_next = ~phase;
    end
    led_next = LED_COUNT'(bar_pattern(int'(count_next), LED_COUNT));
    if (full_idle_next && !phase_next) begin
      led_next = '0;
    end
  end

  // Blink phase register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase <= 1'b1;
    end else begin
      phase <= phase_next;
    end
  end
`else
  assign led_next = LED_COUNT'(bar_pattern(int'(count_next), LED_COUNT));
`endif

  // FSM state, displayed count and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      r_count <= '0;
      led     <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      r_count <= count_next;
      led     <= led_next;
      busy    <= (state_next != ST_IDLE);
    end
  end

  assign o_led   = led;
  assign o_count = r_count;
  assign o_busy  = busy;

endmodule

// File: tb/tb_led_bar_animator.sv
// Scoreboard bench for led_bar_animator (LED_COUNT=4, LEVEL_W=3, STEP_DIV=4,
// BLINK_DIV=3). Cycle n means the sample taken 1 time unit after the n-th
// rising edge following the stimulus drive point.
module tb_led_bar_animator;

  localparam int LED_COUNT = 4;
  localparam int LEVEL_W   = 3;
  localparam int STEP_DIV  = 4;
  localparam int BLINK_DIV = 3;

  logic                 clk;
  logic                 reset;
  logic [LEVEL_W-1:0]   level;
  logic [LED_COUNT-1:0] led;
  logic [LEVEL_W-1:0]   count;
  logic                 busy;

  typedef struct {
    int                   cyc;
    logic [LED_COUNT-1:0] led;
    logic [LEVEL_W-1:0]   cnt;
    logic                 busy;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  led_bar_animator #(
    .LED_COUNT (LED_COUNT),
    .LEVEL_W   (LEVEL_W),
    .STEP_DIV  (STEP_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_level (level),
    .o_led   (led),
    .o_count (count),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void expect_at(int cyc, logic [3:0] l, logic [2:0] n, logic b);
    exp_t e;
    e.cyc  = cyc;
    e.led  = l;
    e.cnt  = n;
    e.busy = b;
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    level = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    sb.delete();
    reset = 1'b1;
    level = 3'd5;
    expect_at(1, 4'b0000, 3'd0, 1'b0);
    expect_at(2, 4'b0000, 3'd0, 1'b0);
    expect_at(3, 4'b0000, 3'd0, 1'b0);
    expect_at(4, 4'b0000, 3'd0, 1'b0);
    expect_at(5, 4'b0000, 3'd0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if ({led, count, busy} !== {e.led, e.cnt, e.busy}) begin
          miscompares++;
          $display("FAIL reset c%0d: led=%b count=%0d busy=%b, expected led=%b count=%0d busy=%b",
                   c, led, count, busy, e.led, e.cnt, e.busy);
        end
      end
      if (c == 3) reset = 1'b0;
    end
  endtask

  task automatic test_rise();
    exp_t e;
    sb.delete();
    do_reset();
    level = 3'd3;
    expect_at(1,  4'b0000, 3'd0, 1'b0);
    expect_at(2,  4'b0000, 3'd0, 1'b1);
    expect_at(5,  4'b0000, 3'd0, 1'b1);
    expect_at(6,  4'b1000, 3'd1, 1'b1);
    expect_at(9,  4'b1000, 3'd1, 1'b1);
    expect_at(10, 4'b1100, 3'd2, 1'b1);
    expect_at(13, 4'b1100, 3'd2, 1'b1);
    expect_at(14, 4'b1110, 3'd3, 1'b0);
    expect_at(16, 4'b1110, 3'd3, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if ({led, count, busy} !== {e.led, e.cnt, e.busy}) begin
          miscompares++;
          $display("FAIL rise c%0d: led=%b count=%0d busy=%b, expected led=%b count=%0d busy=%b",
                   c, led, count, busy, e.led, e.cnt, e.busy);
        end
      end
    end
  endtask

  task automatic test_saturate_fall();
    exp_t e;
    sb.delete();
    do_reset();
    level = 3'd7;
    expect_at(6,  4'b1000, 3'd1, 1'b1);
    expect_at(14, 4'b1110, 3'd3, 1'b1);
    expect_at(18, 4'b1111, 3'd4, 1'b0);
    // level=1 driven at cycle 18: target at 19, FALL at 20, ticks at 24/28/32
    expect_at(19, 4'b1111, 3'd4, 1'b0);
    expect_at(20, 4'b1111, 3'd4, 1'b1);
    expect_at(24, 4'b1110, 3'd3, 1'b1);
    expect_at(28, 4'b1100, 3'd2, 1'b1);
    expect_at(32, 4'b1000, 3'd1, 1'b0);
    expect_at(34, 4'b1000, 3'd1, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if ({led, count, busy} !== {e.led, e.cnt, e.busy}) begin
          miscompares++;
          $display("FAIL sat_fall c%0d: led=%b count=%0d busy=%b, expected led=%b count=%0d busy=%b",
                   c, led, count, busy, e.led, e.cnt, e.busy);
        end
      end
      if (c == 18) level = 3'd1;
    end
  endtask

  task automatic test_reversal();
    exp_t e;
    sb.delete();
    do_reset();
    level = 3'd4;
    expect_at(10, 4'b1100, 3'd2, 1'b1);
    expect_at(13, 4'b1100, 3'd2, 1'b1);
    expect_at(14, 4'b1000, 3'd1, 1'b1);
    expect_at(17, 4'b1000, 3'd1, 1'b1);
    expect_at(18, 4'b0000, 3'd0, 1'b0);
    expect_at(20, 4'b0000, 3'd0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if ({led, count, busy} !== {e.led, e.cnt, e.busy}) begin
          miscompares++;
          $display("FAIL reversal c%0d: led=%b count=%0d busy=%b, expected led=%b count=%0d busy=%b",
                   c, led, count, busy, e.led, e.cnt, e.busy);
        end
      end
      if (c == 12) level = 3'd0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    sb.delete();
    do_reset();
    level = 3'd4;
    expect_at(11, 4'b1100, 3'd2, 1'b1);
    expect_at(12, 4'b0000, 3'd0, 1'b0);
    expect_at(13, 4'b0000, 3'd0, 1'b0);
    expect_at(14, 4'b0000, 3'd0, 1'b0);
    expect_at(15, 4'b0000, 3'd0, 1'b0);
    expect_at(16, 4'b0000, 3'd0, 1'b1);
    expect_at(20, 4'b1000, 3'd1, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if ({led, count, busy} !== {e.led, e.cnt, e.busy}) begin
          miscompares++;
          $display("FAIL reset_mid c%0d: led=%b count=%0d busy=%b, expected led=%b count=%0d busy=%b",
                   c, led, count, busy, e.led, e.cnt, e.busy);
        end
      end
      if (c == 11) reset = 1'b1;
      if (c == 14) reset = 1'b0;
    end
  endtask

  task automatic test_full_bar();
    exp_t       e;
    logic [3:0] off_pat;
`ifdef LED_BAR_BLINK_FULL_EN
    off_pat = 4'b0000;
`else
    off_pat = 4'b1111;
`endif
    sb.delete();
    do_reset();
    level = 3'd4;
    expect_at(18, 4'b1111, 3'd4, 1'b0);
    expect_at(20, 4'b1111, 3'd4, 1'b0);
    expect_at(21, off_pat, 3'd4, 1'b0);
    expect_at(23, off_pat, 3'd4, 1'b0);
    expect_at(24, 4'b1111, 3'd4, 1'b0);
    expect_at(26, 4'b1111, 3'd4, 1'b0);
    expect_at(27, off_pat, 3'd4, 1'b0);
    // level=2 driven at cycle 27: still full-idle at 28, FALL (steady) at 29
    expect_at(28, off_pat, 3'd4, 1'b0);
    expect_at(29, 4'b1111, 3'd4, 1'b1);
    expect_at(32, 4'b1111, 3'd4, 1'b1);
    expect_at(33, 4'b1110, 3'd3, 1'b1);
    expect_at(37, 4'b1100, 3'd2, 1'b0);
    for (int c = 1; c <= 38; c++) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        vectors++;
        if ({led, count, busy} !== {e.led, e.cnt, e.busy}) begin
          miscompares++;
          $display("FAIL full_bar c%0d: led=%b count=%0d busy=%b, expected led=%b count=%0d busy=%b",
                   c, led, count, busy, e.led, e.cnt, e.busy);
        end
      end
      if (c == 27) level = 3'd2;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    level       = '0;
    test_reset();
    test_rise();
    test_saturate_fall();
    test_reversal();
    test_reset_mid();
    test_full_bar();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_bar_animator.md
# led_bar_animator

Parametrised successor to the PWM-state LED indicator. It drives an N-LED bar graph from a level input, filling MSB-first, so level 1 on 4 LEDs shows 1000. Instead of jumping straight to the new pattern, the bar moves one LED per animation step toward the requested level. An optional blink marks a full bar. It sits between the motor PWM FSM (level source) and the board LED pins.

## Interface
- `LED_COUNT`, default 4: number of LEDs in the bar (≥1).
- `LEVEL_W`, default 3: width of the level input; must satisfy 2^LEVEL_W > LED_COUNT.
- `STEP_DIV`, default 10_000_000: clock cycles per animation step (≥1).
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period (≥1); only used with the blink feature.
- `i_clk`  in  1: single clock, rising edge.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_level`  in  LEVEL_W: requested lit count.
- `o_led`  out  LED_COUNT: bar pattern; bit LED_COUNT-1 lights first.
- `o_count`  out  LEVEL_W: currently displayed lit count.
- `o_busy`  out  1: high while the displayed count differs from the target.

## Operation
- Target register `r_target` = min(`i_level`, LED_COUNT), captured every cycle. Values above LED_COUNT saturate.
- Displayed count `r_count` runs from 0 to LED_COUNT.
- `o_led` has its top `r_count` bits set and the rest clear. With count 0, all LEDs are off.
- FSM states:
  - IDLE: `r_count` == `r_target`.
  - RISE: target is above count.
  - FALL: target is below count.
- From IDLE:
  - Go to RISE if `r_target` > `r_count`.
  - Go to FALL if `r_target` < `r_count`.
  - The prescaler is held at 0 while in IDLE.
- In RISE or FALL:
  - The prescaler counts 0 to STEP_DIV-1.
  - At STEP_DIV-1 a step tick fires and the prescaler wraps to 0.
  - On a tick, `r_count` moves ±1. The next state is then re-evaluated against the current `r_target` (RISE, FALL or IDLE).
- Target change mid-animation: only the direction changes, at the next tick. The prescaler is not reset, and an in-flight step is never aborted.
- `o_busy` = (state != IDLE).
- Reset values:
  - `o_led` = 0, `o_count` = 0, `o_busy` = 0.
  - State IDLE, prescaler 0, `r_target` = 0, blink phase = on.

## Timing
- `i_level` change at cycle 0:
  - `r_target` updates at cycle 1.
  - The FSM leaves IDLE at cycle 2.
  - The first `o_led` change is visible at cycle 2+STEP_DIV.
  - Each further step follows STEP_DIV cycles later.
- Full traversal 0 to LED_COUNT takes LED_COUNT×STEP_DIV + 2 cycles.
- STEP_DIV = 1 gives one step per cycle once animating.
- `o_led`, `o_count` and `o_busy` are all registered outputs. There are no combinational paths from `i_level`.
- A reset asserted mid-animation takes effect on the next edge: everything goes to reset values at once, with no ramp-down.

## Configuration
- `LED_BAR_BLINK_FULL_EN` defined:
  - While in IDLE with `r_count` == LED_COUNT, the phase toggles every BLINK_DIV cycles.
  - `o_led` = all-ones during the on phase and all-zeros during the off phase.
  - Phase and blink counter reset to on/0 on every entry to the full-idle condition.
  - Leaving full (a FALL begins) forces a steady pattern on the same cycle.
  - `o_count` and `o_busy` are unaffected by blinking.
- Macro not defined:
  - No blink counter is synthesised and a full bar is steady all-ones.
  - `BLINK_DIV` is ignored.

## Structure
- Shared package/header `led_bar_pkg`:
  - State encoding localparams `ST_IDLE`=0, `ST_RISE`=1, `ST_FALL`=2 (2-bit).
  - Function `bar_pattern(count)` producing the MSB-first fill.
- One sub-module, `led_bar_tick`:
  - Parametrised divider with synchronous clear and enable, emitting a one-cycle tick every DIV enabled cycles.
  - Instantiated for the step tick, and a second time for blink when enabled.

## Test plan
Benches use LED_COUNT=4, LEVEL_W=3, STEP_DIV=4, BLINK_DIV=3.
- Rise: reset, then `i_level`=3 at cycle 0. `o_busy`=1 from cycle 2. `o_led` shows 1000 @6, 1100 @10, 1110 @14. `o_busy`=0 @14.
- Saturation and fall: `i_level`=7 until the bar reads 1111, then `i_level`=1. `o_led` steps 1110, 1100, 1000, 4 cycles apart. `o_count` ends at 1.
- Reversal mid-ramp: `i_level` 0→4, then `i_level`=0 two cycles after `o_led`=1100. Next tick (prescaler not reset) gives 1000, then 0000. No overshoot to 1110.
- Reset mid-animation: `i_reset`=1 while `o_count`=2 and RISE. Next edge gives `o_led`=0000, `o_count`=0, `o_busy`=0; hold with reset.
- Blink (macro defined): reach 1111 idle. `o_led` alternates 1111/0000 every 3 cycles. `i_level`=2 gives steady 1111 at once, then 1110 after 4 cycles. Without the macro, 1111 stays steady.
